// File: rtl/lsu_lsq_ctrl_pkg.sv
// Shared definitions for the load/store queue sequencing controller.
// Default depth plus the status-bit pattern that makes an entry issuable.
package lsu_lsq_ctrl_pkg;

  localparam int LSQ_DEPTH_DEF = 8;
  localparam int LSQ_PTR_W_DEF = $clog2(LSQ_DEPTH_DEF);

  typedef struct packed {
    logic vld;
    logic virt;
    logic awake;
    logic exec;
    logic succ;
    logic exc;
  } lsq_stat_t;

  // Every status bit is significant; MATCH gives the value each must hold.
  localparam lsq_stat_t ISSUE_CARE  = '{vld: 1'b1, virt: 1'b1, awake: 1'b1,
                                        exec: 1'b1, succ: 1'b1, exc: 1'b1};
  localparam lsq_stat_t ISSUE_MATCH = '{vld: 1'b1, virt: 1'b0, awake: 1'b1,
                                        exec: 1'b0, succ: 1'b0, exc: 1'b0};

  function automatic logic stat_issuable(input lsq_stat_t s);
    return ((s ^ ISSUE_MATCH) & ISSUE_CARE) == '0;
  endfunction

  function automatic logic stat_done(input lsq_stat_t s);
    return s.vld & (s.succ | s.exc);
  endfunction

endpackage

// File: rtl/lsu_lsq_age_sel.sv
// Oldest-first picker: rotate requests so that base is bit 0, take the lowest
// set bit, then rotate the winner back to an absolute index.
module lsu_lsq_age_sel #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [PTR_W-1:0] base,
  output logic             vld,
  output logic [PTR_W-1:0] idx,
  output logic [PTR_W-1:0] age
);

  logic [DEPTH-1:0] rot;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rot
    localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
    logic [PTR_W-1:0] pos;
    assign pos     = base + OFF;
    assign rot[gi] = req[pos];
  end

  // Scan from the youngest slot down so the oldest hit is written last.
  always_comb begin
    vld = 1'b0;
    age = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        vld = 1'b1;
        age = PTR_W'(j);
      end
    end
  end

  assign idx = base + age;

endmodule

// File: rtl/lsu_lsq_ctrl.sv
// Load/store queue sequencing controller: circular allocation, oldest-first
// issue, response strobes and in-order retire. Optional fencing: LSQ_FENCE_EN.
module lsu_lsq_ctrl
  import lsu_lsq_ctrl_pkg::*;
#(
  parameter int LSQ_DEPTH = LSQ_DEPTH_DEF,
  parameter int LSQ_PTR_W = $clog2(LSQ_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_vld_i,
  output logic                 alloc_rdy_o,
  output logic [LSQ_PTR_W-1:0] alloc_idx_o,
  output logic [LSQ_DEPTH-1:0] entry_alloc_o,
  input  logic [LSQ_DEPTH-1:0] entry_vld_i,
  input  logic [LSQ_DEPTH-1:0] entry_virt_i,
  input  logic [LSQ_DEPTH-1:0] entry_awake_i,
  input  logic [LSQ_DEPTH-1:0] entry_exec_i,
  input  logic [LSQ_DEPTH-1:0] entry_succ_i,
  input  logic [LSQ_DEPTH-1:0] entry_exc_i,
  input  logic [LSQ_DEPTH-1:0] entry_fenced_i,
  output logic                 issue_vld_o,
  input  logic                 issue_rdy_i,
  output logic [LSQ_PTR_W-1:0] issue_idx_o,
  output logic [LSQ_DEPTH-1:0] entry_exec_o,
  input  logic                 resp_vld_i,
  input  logic [LSQ_PTR_W-1:0] resp_idx_i,
  input  logic                 resp_replay_i,
  output logic [LSQ_DEPTH-1:0] entry_replay_o,
  output logic [LSQ_DEPTH-1:0] entry_succ_o,
  output logic                 commit_rdy_o,
  input  logic                 commit_vld_i,
  output logic [LSQ_DEPTH-1:0] entry_invld_o,
  output logic [LSQ_PTR_W-1:0] head_o,
  output logic [LSQ_PTR_W-1:0] tail_o,
  output logic [LSQ_PTR_W:0]   count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  logic [LSQ_PTR_W-1:0] head_q;
  logic [LSQ_PTR_W-1:0] tail_q;
  logic [LSQ_PTR_W:0]   count_q;

  logic kill;
  logic full;
  logic empty;
  logic alloc_fire;
  logic issue_fire;
  logic commit_fire;
  logic resp_ok;

  logic [LSQ_DEPTH-1:0] issuable;
  logic [LSQ_DEPTH-1:0] eligible;
  logic                 sel_vld;
  logic [LSQ_PTR_W-1:0] sel_idx;
  logic [LSQ_PTR_W-1:0] sel_age_unused;
  lsq_stat_t            head_stat;

  assign kill  = rst | flush;
  assign full  = (count_q == (LSQ_PTR_W+1)'(LSQ_DEPTH));
  assign empty = (count_q == '0);

  for (genvar gi = 0; gi < LSQ_DEPTH; gi++) begin : g_stat
    lsq_stat_t stat;
    assign stat = {entry_vld_i[gi], entry_virt_i[gi], entry_awake_i[gi],
                   entry_exec_i[gi], entry_succ_i[gi], entry_exc_i[gi]};
    assign issuable[gi] = stat_issuable(stat);
  end

`ifdef LSQ_FENCE_EN
  // An outstanding fence hides every younger entry; it may go itself only from the head.
  logic [LSQ_DEPTH-1:0] fence_pend;
  logic                 fence_vld;
  logic [LSQ_PTR_W-1:0] fence_age;
  logic [LSQ_PTR_W-1:0] fence_idx_unused;

  for (genvar gi = 0; gi < LSQ_DEPTH; gi++) begin : g_fence
    logic [LSQ_PTR_W-1:0] age_i;
    assign fence_pend[gi] = entry_fenced_i[gi] & entry_vld_i[gi] &
                            ~entry_succ_i[gi] & ~entry_exc_i[gi];
    assign age_i          = LSQ_PTR_W'(gi) - head_q;
    assign eligible[gi]   = issuable[gi] &
                            (~fence_vld | (age_i < fence_age) |
                             ((age_i == '0) & (fence_age == '0)));
  end

  lsu_lsq_age_sel #(
    .DEPTH (LSQ_DEPTH),
    .PTR_W (LSQ_PTR_W)
  ) u_fence_sel (
    .req  (fence_pend),
    .base (head_q),
    .vld  (fence_vld),
    .idx  (fence_idx_unused),
    .age  (fence_age)
  );
`else
  logic unused_fenced;
  assign unused_fenced = ^entry_fenced_i;
  assign eligible      = issuable;
`endif

  lsu_lsq_age_sel #(
    .DEPTH (LSQ_DEPTH),
    .PTR_W (LSQ_PTR_W)
  ) u_issue_sel (
    .req  (eligible),
    .base (head_q),
    .vld  (sel_vld),
    .idx  (sel_idx),
    .age  (sel_age_unused)
  );

  assign head_stat = {entry_vld_i[head_q], entry_virt_i[head_q], entry_awake_i[head_q],
                      entry_exec_i[head_q], entry_succ_i[head_q], entry_exc_i[head_q]};

  assign alloc_rdy_o  = ~full;
  assign alloc_idx_o  = tail_q;
  assign issue_vld_o  = sel_vld & ~empty & ~kill;
  assign issue_idx_o  = sel_idx;
  assign commit_rdy_o = stat_done(head_stat) & ~empty & ~kill;

  assign alloc_fire  = alloc_vld_i & ~full & ~kill;
  assign issue_fire  = issue_vld_o & issue_rdy_i;
  assign commit_fire = commit_vld_i & commit_rdy_o;
  // Responses for empty slots are dropped rather than corrupting a future occupant.
  assign resp_ok     = resp_vld_i & entry_vld_i[resp_idx_i] & ~kill;

  for (genvar gi = 0; gi < LSQ_DEPTH; gi++) begin : g_strobe
    localparam logic [LSQ_PTR_W-1:0] IDX = LSQ_PTR_W'(gi);
    assign entry_alloc_o[gi]  = alloc_fire & (tail_q == IDX);
    assign entry_exec_o[gi]   = issue_fire & (sel_idx == IDX);
    assign entry_replay_o[gi] = resp_ok & resp_replay_i & (resp_idx_i == IDX);
    assign entry_succ_o[gi]   = resp_ok & ~resp_replay_i & (resp_idx_i == IDX);
    assign entry_invld_o[gi]  = commit_fire & (head_q == IDX);
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + 1'b1;
      if (commit_fire) head_q <= head_q + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;

`ifndef SYNTHESIS
  resp_targets_valid_entry: assert property (
    @(posedge clk) disable iff (kill) !(resp_vld_i && !entry_vld_i[resp_idx_i]));
`endif

endmodule

// File: tb/tb_lsu_lsq_ctrl.sv
// Bench for lsu_lsq_ctrl: directed table, corner sequences and a randomized run
// against a queue-level reference model (head + occupancy, age-ordered search).
module tb_lsu_lsq_ctrl;
  localparam int D  = 8;
  localparam int PW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, alloc_vld, issue_rdy, resp_vld, resp_replay, commit_vld;
  logic [PW-1:0] resp_idx;
  logic [D-1:0]  s_vld, s_virt, s_awake, s_exec, s_succ, s_exc, s_fenced;

  logic          alloc_rdy, issue_vld, commit_rdy, empty, full;
  logic [PW-1:0] alloc_idx, issue_idx, head, tail;
  logic [PW:0]   count;
  logic [D-1:0]  entry_alloc, entry_exec, entry_replay, entry_succ, entry_invld;

  lsu_lsq_ctrl #(.LSQ_DEPTH(D), .LSQ_PTR_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_vld_i    (alloc_vld),
    .alloc_rdy_o    (alloc_rdy),
    .alloc_idx_o    (alloc_idx),
    .entry_alloc_o  (entry_alloc),
    .entry_vld_i    (s_vld),
    .entry_virt_i   (s_virt),
    .entry_awake_i  (s_awake),
    .entry_exec_i   (s_exec),
    .entry_succ_i   (s_succ),
    .entry_exc_i    (s_exc),
    .entry_fenced_i (s_fenced),
    .issue_vld_o    (issue_vld),
    .issue_rdy_i    (issue_rdy),
    .issue_idx_o    (issue_idx),
    .entry_exec_o   (entry_exec),
    .resp_vld_i     (resp_vld),
    .resp_idx_i     (resp_idx),
    .resp_replay_i  (resp_replay),
    .entry_replay_o (entry_replay),
    .entry_succ_o   (entry_succ),
    .commit_rdy_o   (commit_rdy),
    .commit_vld_i   (commit_vld),
    .entry_invld_o  (entry_invld),
    .head_o         (head),
    .tail_o         (tail),
    .count_o        (count),
    .empty_o        (empty),
    .full_o         (full)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_head  = 0;
  int m_cnt   = 0;

  typedef struct {
    logic [7:0] vld, virt, awake, exec, succ, exc;
    bit         exp_iv;
    int         exp_idx;
    bit         exp_crdy;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; alloc_vld = 0; issue_rdy = 0; resp_vld = 0;
    resp_replay = 0; commit_vld = 0; resp_idx = '0;
    s_vld = '0; s_virt = '0; s_awake = '0; s_exec = '0; s_succ = '0;
    s_exc = '0; s_fenced = '0;
  endtask

  // Oldest issuable entry by age from the head, honouring fences when enabled.
  task automatic model_pick(output bit found, output int idx);
    int fpos;
    fpos  = -1;
    found = 0;
    idx   = 0;
`ifdef LSQ_FENCE_EN
    for (int k = 0; k < D; k++) begin
      int i;
      i = (m_head + k) % D;
      if (fpos < 0 && s_fenced[i] && s_vld[i] && !s_succ[i] && !s_exc[i]) fpos = k;
    end
`endif
    for (int k = 0; k < D; k++) begin
      int i;
      bit ok;
      i  = (m_head + k) % D;
      ok = s_vld[i] && !s_virt[i] && s_awake[i] && !s_exec[i] && !s_succ[i] && !s_exc[i];
      if (fpos >= 0 && !(k < fpos || (k == fpos && k == 0))) ok = 0;
      if (ok && !found) begin
        found = 1;
        idx   = i;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge, compare every output with the model, then advance the model.
  task automatic step(input string tag);
    int tl, sidx;
    bit sv, kill, emp, ful, afire, iv, crdy, cfire, rok;
    logic [7:0] e_alloc, e_exec, e_rep, e_succ, e_inv;
    @(negedge clk);
    kill  = rst || flush;
    emp   = (m_cnt == 0);
    ful   = (m_cnt == D);
    tl    = (m_head + m_cnt) % D;
    afire = alloc_vld && !ful && !kill;
    model_pick(sv, sidx);
    iv    = sv && !emp && !kill;
    crdy  = !emp && !kill && s_vld[m_head] && (s_succ[m_head] || s_exc[m_head]);
    cfire = crdy && commit_vld;
    rok   = resp_vld && s_vld[resp_idx] && !kill;
    e_alloc = afire ? 8'(1 << tl) : 8'h00;
    e_exec  = (iv && issue_rdy) ? 8'(1 << sidx) : 8'h00;
    e_rep   = (rok && resp_replay) ? 8'(1 << resp_idx) : 8'h00;
    e_succ  = (rok && !resp_replay) ? 8'(1 << resp_idx) : 8'h00;
    e_inv   = cfire ? 8'(1 << m_head) : 8'h00;
    chk("head", head, m_head);
    chk("tail", tail, tl);
    chk("count", count, m_cnt);
    chk("empty", empty, emp);
    chk("full", full, ful);
    chk("alloc_rdy", alloc_rdy, !ful);
    chk("alloc_idx", alloc_idx, tl);
    chk("issue_vld", issue_vld, iv);
    if (iv) chk("issue_idx", issue_idx, sidx);
    chk("commit_rdy", commit_rdy, crdy);
    chk("entry_alloc", entry_alloc, e_alloc);
    chk("entry_exec", entry_exec, e_exec);
    chk("entry_replay", entry_replay, e_rep);
    chk("entry_succ", entry_succ, e_succ);
    chk("entry_invld", entry_invld, e_inv);
    $display("[TB] %-8s head=%0d cnt=%0d issue=%0b/%0d commit_rdy=%0b alloc=%02h exec=%02h invld=%02h",
             tag, head, count, issue_vld, issue_idx, commit_rdy, entry_alloc, entry_exec, entry_invld);
    if (kill) begin
      m_head = 0;
      m_cnt  = 0;
    end else begin
      m_head = (m_head + int'(cfire)) % D;
      m_cnt  = m_cnt + int'(afire) - int'(cfire);
    end
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 7, 1'b0};
    tbl[2] = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 4, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'h3F, 8'h00, 8'h00, 1'b1, 6, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 0, 1'b1};
    tbl[5] = '{8'hFF, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1, 1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0};
    tbl[7] = '{8'hF0, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b1, 5, 1'b0};
    tbl[8] = '{8'hFF, 8'h55, 8'hFF, 8'h02, 8'h08, 8'h20, 1'b1, 7, 1'b0};

    idle_inputs();
    rst = 1;
    step("reset");
    adv(); idle_inputs();
    step("idle");
    chk("rst_head", head, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_alloc_rdy", alloc_rdy, 1);
    chk("rst_issue_vld", issue_vld, 0);

    // Fill the queue, then try one more allocation.
    for (int k = 0; k < D; k++) begin
      adv(); idle_inputs();
      alloc_vld = 1; s_virt = 8'hFF;
      step("alloc");
      chk("alloc_seq_idx", alloc_idx, k);
    end
    adv(); idle_inputs();
    alloc_vld = 1; s_virt = 8'hFF;
    step("alloc9");
    chk("full_flag", full, 1);
    chk("full_no_rdy", alloc_rdy, 0);
    chk("full_no_alloc", entry_alloc, 0);

    for (int i = 0; i < 9; i++) begin
      adv(); idle_inputs();
      s_vld = tbl[i].vld; s_virt = tbl[i].virt; s_awake = tbl[i].awake;
      s_exec = tbl[i].exec; s_succ = tbl[i].succ; s_exc = tbl[i].exc;
      step($sformatf("tbl%0d", i));
      chk("tbl_issue_vld", issue_vld, tbl[i].exp_iv);
      if (tbl[i].exp_iv) chk("tbl_issue_idx", issue_idx, tbl[i].exp_idx);
      chk("tbl_commit_rdy", commit_rdy, tbl[i].exp_crdy);
    end

    // Full queue: commit and alloc together, allocation must still be refused.
    adv(); idle_inputs();
    s_vld = 8'hFF; s_virt = 8'hFF; s_succ = 8'h01; commit_vld = 1; alloc_vld = 1;
    step("full_cm");
    chk("fullcm_invld", entry_invld, 8'h01);
    chk("fullcm_alloc", entry_alloc, 0);
    adv(); idle_inputs();
    step("after_cm");
    chk("fullcm_count", count, 7);

    // Move head to 6 and tail to 2, then check the wrapped age order.
    for (int k = 0; k < 5; k++) begin
      adv(); idle_inputs();
      s_vld = 8'hFF; s_virt = 8'hFF; s_succ = 8'hFF; commit_vld = 1;
      step("drain");
    end
    for (int k = 0; k < 2; k++) begin
      adv(); idle_inputs();
      alloc_vld = 1; s_virt = 8'hFF;
      step("alloc");
    end
    adv(); idle_inputs();
    s_vld = 8'b1100_0011; s_awake = 8'b1000_0010;
    step("wrap");
    chk("wrap_head", head, 6);
    chk("wrap_tail", tail, 2);
    chk("wrap_issue_vld", issue_vld, 1);
    chk("wrap_issue_idx", issue_idx, 7);

    // Replay of entry 3 and reselection once its exec bit clears.
    adv(); idle_inputs(); rst = 1;
    step("reset");
    for (int k = 0; k < 4; k++) begin
      adv(); idle_inputs();
      alloc_vld = 1; s_virt = 8'hFF;
      step("alloc");
    end
    adv(); idle_inputs();
    s_vld = 8'h0F; s_awake = 8'h08; issue_rdy = 1;
    step("issue3");
    chk("rp_issue_idx", issue_idx, 3);
    chk("rp_exec", entry_exec, 8'h08);
    adv(); idle_inputs();
    s_vld = 8'h0F; s_awake = 8'h08; s_exec = 8'h08; issue_rdy = 1;
    step("exec3");
    chk("rp_no_reissue", issue_vld, 0);
    adv(); idle_inputs();
    s_vld = 8'h0F; s_awake = 8'h08; s_exec = 8'h08;
    resp_vld = 1; resp_idx = 3; resp_replay = 1;
    step("replay3");
    chk("rp_replay", entry_replay, 8'h08);
    chk("rp_succ", entry_succ, 0);
    adv(); idle_inputs();
    s_vld = 8'h0F; s_awake = 8'h08;
    step("reiss3");
    chk("rp_reissue_vld", issue_vld, 1);
    chk("rp_reissue_idx", issue_idx, 3);

    // Flush with five entries and every handshake presented.
    adv(); idle_inputs();
    alloc_vld = 1; s_virt = 8'hFF;
    step("alloc");
    adv(); idle_inputs();
    flush = 1; alloc_vld = 1; issue_rdy = 1; commit_vld = 1;
    s_vld = 8'h1F; s_awake = 8'h08; s_succ = 8'h01;
    resp_vld = 1; resp_idx = 3;
    step("flush");
    chk("fl_count_before", count, 5);
    chk("fl_alloc", entry_alloc, 0);
    chk("fl_exec", entry_exec, 0);
    chk("fl_succ", entry_succ, 0);
    chk("fl_invld", entry_invld, 0);
    adv(); idle_inputs();
    step("postfl");
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_head", head, 0);
    chk("fl_tail", tail, 0);

    // Fence on entry 1 with entry 2 ready behind it.
    for (int k = 0; k < 3; k++) begin
      adv(); idle_inputs();
      alloc_vld = 1; s_virt = 8'hFF;
      step("alloc");
    end
    adv(); idle_inputs();
    s_vld = 8'h07; s_virt = 8'h03; s_awake = 8'h07; s_fenced = 8'h02;
    step("fence");
`ifdef LSQ_FENCE_EN
    chk("fence_block", issue_vld, 0);
`else
    chk("fence_off_vld", issue_vld, 1);
    chk("fence_off_idx", issue_idx, 2);
`endif
    adv(); idle_inputs();
    s_vld = 8'h07; s_virt = 8'h03; s_awake = 8'h07; s_fenced = 8'h02; s_succ = 8'h02;
    step("fence_ok");
    chk("fence_rel_vld", issue_vld, 1);
    chk("fence_rel_idx", issue_idx, 2);

    // Randomized traffic against the model.
    adv(); idle_inputs(); rst = 1;
    step("reset");
    for (int n = 0; n < 1500; n++) begin
      adv(); idle_inputs();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 99) < 2);
      alloc_vld  = ($urandom_range(0, 99) < 60);
      commit_vld = ($urandom_range(0, 99) < 50);
      issue_rdy  = ($urandom_range(0, 99) < 70);
      s_vld      = 8'($urandom);
      s_virt     = 8'($urandom & $urandom);
      s_awake    = 8'($urandom | $urandom);
      s_exec     = 8'($urandom & $urandom);
      s_succ     = 8'($urandom & $urandom);
      s_exc      = 8'($urandom & $urandom & $urandom);
      s_fenced   = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 1) == 1) begin
        s_vld[m_head]  = 1'b1;
        s_succ[m_head] = 1'b1;
      end
      if (s_vld != 0 && $urandom_range(0, 99) < 40) begin
        int r;
        r = $urandom_range(0, D - 1);
        while (!s_vld[r]) r = (r + 1) % D;
        resp_vld    = 1;
        resp_idx    = PW'(r);
        resp_replay = 1'($urandom_range(0, 1));
      end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
